vga_canvas_grid: RTL and testbench
==================================

# vga_canvas_grid

Parametrised VGA drawing canvas: generates sync and pixel colour for a configurable video mode, tracks a saturating mouse cursor from PS/2 movement packets, and paints or erases a GRID_W×GRID_H bit-image with a plus-shaped brush. It sits between the PS/2 mouse decoder and the VGA pins. The `image` vector feeds the DNN classifier directly. It adds an erase mode, a global clear, cursor clamping, edge-safe brush writes and fully synchronous single-clock timing.

## Interface
- H_SYNC, 128, horizontal sync pulse (pixels)
- H_BP, 88, horizontal back porch
- H_ACT, 800, horizontal active pixels
- H_FP, 40, horizontal front porch; line period = sum of the four H parameters (default 1056)
- V_SYNC, 4, vertical sync pulse (lines)
- V_BP, 23, vertical back porch
- V_ACT, 600, vertical active lines
- V_FP, 1, vertical front porch; frame period = sum of the four V parameters (default 628)
- GRID_W, 32, image columns
- GRID_H, 32, image rows
- CELL_SHIFT, 4, log2 of cell edge in pixels (16×16-pixel cells)
- CURSOR_W, 8, cursor box width (pixels)
- CURSOR_H, 16, cursor box height (pixels)

Ports:
- clkVga  in  1  pixel clock, the only clock; all state on its rising edge
- iRstN  in  1  asynchronous, active-low reset
- iMoveValid  in  1  one-cycle strobe; iDx/iDy valid
- iDx  in  9  signed two's-complement X delta; positive = right
- iDy  in  9  signed two's-complement Y delta; positive = up
- iButton  in  3  [0] left = paint, [1] right = erase, [2] middle = colour only
- iClear  in  1  level; clears image
- oRed / oGreen / oBlue  out  4 each  pixel colour
- oHs  out  1  horizontal sync, active low
- oVs  out  1  vertical sync, active low
- oCursorX  out  11  cursor pixel column
- oCursorY  out  11  cursor pixel row
- image  out  GRID_W*GRID_H  bit-image; bit index = row*GRID_W + col

## Operation
- **Counters**
  - hCnt runs 0..H_period-1, then wraps.
  - vCnt increments only in the cycle hCnt wraps, and runs 0..V_period-1.
  - Both counters reset to 0.
- **Active region**
  - hCnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACT-1] and vCnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACT-1].
  - hPos and vPos are the offsets from the region start.
- **Cursor**
  - On iMoveValid, newX = X + sext(iDx) and newY = Y − sext(iDy), computed 12-bit signed.
  - Both coordinates saturate to [0, H_ACT-1] and [0, V_ACT-1].
  - With no strobe, the cursor holds. Reset value is (0,0).
- **Cursor cell**: cc = X>>CELL_SHIFT, cr = Y>>CELL_SHIFT. The cell is inside the grid iff cc<GRID_W and cr<GRID_H.
- **Image writes**, one per cycle, in priority order:
  1. iClear: all bits cleared to 0.
  2. iButton[0]: set the brush.
  3. iButton[1]: clear the brush.
- **Brush**
  - The brush is the cursor cell plus its N/S/E/W neighbours.
  - A neighbour outside the grid is skipped; there is no wrap-around.
  - If the cursor cell is outside the grid, nothing is written.
  - Writes repeat every cycle while a button is held; repeated writes are idempotent.
- **Colour priority** (active region):
  1. Cursor box (X ≤ hPos < X+CURSOR_W, Y ≤ vPos < Y+CURSOR_H): green F/F=0 green only if iButton[2]; else blue (0,0,F) if iButton[1]; else red (F,0,0).
  2. Pixel inside the grid with its image bit set: magenta (F,0,F).
  3. Pixel inside the grid with its bit clear: grey (8,8,8).
  4. Active pixel outside the grid: black (0,0,0).
- **Blanking**: outside the active region, colour is (0,0,0).

## Timing
- Reset values:
  - oRed/oGreen/oBlue = 0
  - oHs = oVs = 1
  - image = 0
  - oCursorX = oCursorY = 0
  - hCnt = vCnt = 0
- Colour, oHs and oVs are registered from the same counter state, so all have 1-cycle latency and stay aligned.
  - oHs is low for exactly H_SYNC cycles per line.
  - oVs is low for exactly V_SYNC × H_period cycles per frame.
- A cursor update is visible on oCursorX/Y one cycle after iMoveValid.
- An image write is visible on `image` one cycle after the button or iClear is sampled. Painting uses the pre-update cursor when iMoveValid coincides with a button.
- Reset asserted mid-frame zeroes everything immediately. After deassertion, the first line starts at hCnt = 0.

## Test plan
- **Reset and sync**: default parameters, release reset → oHs low for 128 of every 1056 cycles; oVs low for 4224 cycles of every 663168; all colours 0 during blanking.
- **Cursor saturation**
  - From (0,0), iDx = −5 → X stays 0.
  - Ten strobes of iDx = +255 → X = 799.
  - iDy = +3 from Y = 10 → Y = 7.
  - iDy = −255 ×3 → Y = 599.
- **Edge brush**: cursor at (0,0), hold iButton[0] → image bits 0, 1 and 32 set; all other bits 0, including bits 31 and 992 (proves no wrap).
- **Erase and priority**
  - Paint at cell (5,5) → bits 165, 164, 166, 133 and 197 set.
  - Then iButton[0] and iButton[1] together → bits unchanged.
  - Then iButton[1] alone → those bits cleared.
  - Then iClear with iButton[0] → image = 0.
- **Pixel colour**
  - Bit 0 set, cursor at (100,100) → pixel (hPos 0, vPos 0) = (F,0,F).
  - Pixel (20,0) = (8,8,8).
  - Pixel (600,0) = (0,0,0).
  - Pixel (100,100) = red; with iButton[2] held = green.
- **Outside grid**: cursor at (700,50), hold iButton[0] → image unchanged.

Source files
------------

// File: rtl/vga_canvas_grid.sv
// vga_canvas_grid
//   VGA drawing canvas. Free-running raster counters produce sync and pixel
//   colour. A saturating cursor follows PS/2 movement packets. A plus-shaped
//   brush paints or erases a GRID_W x GRID_H bit-image at the cursor cell.
//
// Ports
//   clkVga            pixel clock; every register uses its rising edge
//   iRstN             asynchronous active-low reset
//   iMoveValid        one-cycle strobe qualifying iDx/iDy
//   iDx, iDy          signed 9-bit deltas (+x = right, +y = up)
//   iButton           [0] paint, [1] erase, [2] cursor colour only
//   iClear            level; clears the whole image
//   oRed/oGreen/oBlue 4-bit pixel colour, one cycle behind the counters
//   oHs, oVs          active-low syncs, aligned with the colour
//   oCursorX/Y        cursor pixel position
//   image             bit-image, bit index = row*GRID_W + col
module vga_canvas_grid #(
  parameter int H_SYNC     = 128,
  parameter int H_BP       = 88,
  parameter int H_ACT      = 800,
  parameter int H_FP       = 40,
  parameter int V_SYNC     = 4,
  parameter int V_BP       = 23,
  parameter int V_ACT      = 600,
  parameter int V_FP       = 1,
  parameter int GRID_W     = 32,
  parameter int GRID_H     = 32,
  parameter int CELL_SHIFT = 4,
  parameter int CURSOR_W   = 8,
  parameter int CURSOR_H   = 16
) (
  input  logic                       clkVga,
  input  logic                       iRstN,
  input  logic                       iMoveValid,
  input  logic [8:0]                 iDx,
  input  logic [8:0]                 iDy,
  input  logic [2:0]                 iButton,
  input  logic                       iClear,
  output logic [3:0]                 oRed,
  output logic [3:0]                 oGreen,
  output logic [3:0]                 oBlue,
  output logic                       oHs,
  output logic                       oVs,
  output logic [10:0]                oCursorX,
  output logic [10:0]                oCursorY,
  output logic [GRID_W*GRID_H-1:0]   image
);

  localparam int H_TOT   = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOT   = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int H_START = H_SYNC + H_BP;
  localparam int V_START = V_SYNC + V_BP;
  localparam int HCW     = $clog2(H_TOT);
  localparam int VCW     = $clog2(V_TOT);
  localparam int IMG_N   = GRID_W * GRID_H;
  localparam int IW      = $clog2(IMG_N);
  localparam logic signed [11:0] X_MAX = 12'(H_ACT - 1);
  localparam logic signed [11:0] Y_MAX = 12'(V_ACT - 1);

  // Clamp a signed 12-bit coordinate into [0, max_v].
  function automatic logic [10:0] sat_coord(input logic signed [11:0] v,
                                            input logic signed [11:0] max_v);
    if (v < 12'sd0)       return 11'd0;
    else if (v > max_v)   return max_v[10:0];
    else                  return v[10:0];
  endfunction

  // Flat image index of cell (r, c); only meaningful for in-grid cells.
  function automatic logic [IW-1:0] cell_idx(input logic [10:0] r,
                                             input logic [10:0] c);
    logic [21:0] t;
    t = {11'd0, r} * 22'(GRID_W) + {11'd0, c};
    return t[IW-1:0];
  endfunction

  // ---- stage p0: raster counters and cursor state ----
  logic [HCW-1:0] h_cnt_p0;
  logic [VCW-1:0] v_cnt_p0;
  logic [10:0]    cur_x;
  logic [10:0]    cur_y;

  always_ff @(posedge clkVga or negedge iRstN) begin
    if (!iRstN) begin
      h_cnt_p0 <= '0;
      v_cnt_p0 <= '0;
    end else if (h_cnt_p0 == HCW'(H_TOT - 1)) begin
      h_cnt_p0 <= '0;
      v_cnt_p0 <= (v_cnt_p0 == VCW'(V_TOT - 1)) ? '0 : v_cnt_p0 + 1'b1;
    end else begin
      h_cnt_p0 <= h_cnt_p0 + 1'b1;
    end
  end

  logic signed [11:0] dx_s, dy_s, nx, ny;
  assign dx_s = $signed({{3{iDx[8]}}, iDx});
  assign dy_s = $signed({{3{iDy[8]}}, iDy});
  // Screen Y grows downward, so a positive (upward) mouse delta subtracts.
  assign nx = $signed({1'b0, cur_x}) + dx_s;
  assign ny = $signed({1'b0, cur_y}) - dy_s;

  always_ff @(posedge clkVga or negedge iRstN) begin
    if (!iRstN) begin
      cur_x <= '0;
      cur_y <= '0;
    end else if (iMoveValid) begin
      cur_x <= sat_coord(nx, X_MAX);
      cur_y <= sat_coord(ny, Y_MAX);
    end
  end

  // Brush mask from the current (pre-update) cursor cell; neighbours that
  // fall off the grid are dropped rather than wrapped.
  logic [10:0]      cc, cr;
  logic             cur_in_grid;
  logic [IMG_N-1:0] brush_mask;
  assign cc          = cur_x >> CELL_SHIFT;
  assign cr          = cur_y >> CELL_SHIFT;
  assign cur_in_grid = (cc < 11'(GRID_W)) && (cr < 11'(GRID_H));

  always_comb begin
    brush_mask = '0;
    if (cur_in_grid) begin
      brush_mask[cell_idx(cr, cc)] = 1'b1;
      if (cc != 11'd0)             brush_mask[cell_idx(cr, cc - 11'd1)] = 1'b1;
      if (cc < 11'(GRID_W - 1))    brush_mask[cell_idx(cr, cc + 11'd1)] = 1'b1;
      if (cr != 11'd0)             brush_mask[cell_idx(cr - 11'd1, cc)] = 1'b1;
      if (cr < 11'(GRID_H - 1))    brush_mask[cell_idx(cr + 11'd1, cc)] = 1'b1;
    end
  end

  always_ff @(posedge clkVga or negedge iRstN) begin
    if (!iRstN)          image <= '0;
    else if (iClear)     image <= '0;
    else if (iButton[0]) image <= image | brush_mask;
    else if (iButton[1]) image <= image & ~brush_mask;
  end

  // Pixel decode from the current counter state.
  logic        vld_p0;
  logic [10:0] h_pos, v_pos, pc, pr;
  logic        pix_in_grid, in_box;
  logic [3:0]  red_n, green_n, blue_n;

  assign vld_p0 = (h_cnt_p0 >= HCW'(H_START)) && (h_cnt_p0 < HCW'(H_START + H_ACT)) &&
                  (v_cnt_p0 >= VCW'(V_START)) && (v_cnt_p0 < VCW'(V_START + V_ACT));
  assign h_pos  = 11'(h_cnt_p0 - HCW'(H_START));
  assign v_pos  = 11'(v_cnt_p0 - VCW'(V_START));
  assign pc     = h_pos >> CELL_SHIFT;
  assign pr     = v_pos >> CELL_SHIFT;
  assign pix_in_grid = (pc < 11'(GRID_W)) && (pr < 11'(GRID_H));
  // 12-bit compare so the box edge near the right/bottom border cannot overflow.
  assign in_box = ({1'b0, h_pos} >= {1'b0, cur_x}) &&
                  ({1'b0, h_pos} <  {1'b0, cur_x} + 12'(CURSOR_W)) &&
                  ({1'b0, v_pos} >= {1'b0, cur_y}) &&
                  ({1'b0, v_pos} <  {1'b0, cur_y} + 12'(CURSOR_H));

  always_comb begin
    red_n   = 4'h0;
    green_n = 4'h0;
    blue_n  = 4'h0;
    if (vld_p0) begin
      if (in_box) begin
        if (iButton[2])      green_n = 4'hF;
        else if (iButton[1]) blue_n  = 4'hF;
        else                 red_n   = 4'hF;
      end else if (pix_in_grid) begin
        if (image[cell_idx(pr, pc)]) begin
          red_n  = 4'hF;
          blue_n = 4'hF;
        end else begin
          red_n   = 4'h8;
          green_n = 4'h8;
          blue_n  = 4'h8;
        end
      end
    end
  end

  // ---- stage p1: registered colour and syncs ----
  logic [3:0] red_p1, green_p1, blue_p1;
  logic       hs_p1, vs_p1;

  always_ff @(posedge clkVga or negedge iRstN) begin
    if (!iRstN) begin
      red_p1   <= 4'h0;
      green_p1 <= 4'h0;
      blue_p1  <= 4'h0;
      hs_p1    <= 1'b1;
      vs_p1    <= 1'b1;
    end else begin
      red_p1   <= red_n;
      green_p1 <= green_n;
      blue_p1  <= blue_n;
      hs_p1    <= !(h_cnt_p0 < HCW'(H_SYNC));
      vs_p1    <= !(v_cnt_p0 < VCW'(V_SYNC));
    end
  end

  assign oRed     = red_p1;
  assign oGreen   = green_p1;
  assign oBlue    = blue_p1;
  assign oHs      = hs_p1;
  assign oVs      = vs_p1;
  assign oCursorX = cur_x;
  assign oCursorY = cur_y;

endmodule

// File: tb/tb_vga_canvas_grid.sv
// Testbench for vga_canvas_grid at default parameters: reset values, sync
// pulse widths, cursor saturation table, brush/erase/clear sequences,
// pixel colours at chosen raster positions and mid-frame reset.
module tb_vga_canvas_grid;

  localparam int IMG = 1024;
  localparam int LINE = 1056;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            mv;
  logic [8:0]      dx, dy;
  logic [2:0]      btn;
  logic            clr;
  logic [3:0]      r, g, b;
  logic            hs, vs;
  logic [10:0]     cx, cy;
  logic [IMG-1:0]  img;

  int checks = 0;
  int failures = 0;
  int cyc;

  vga_canvas_grid dut (
    .clkVga(clk), .iRstN(rst_n), .iMoveValid(mv), .iDx(dx), .iDy(dy),
    .iButton(btn), .iClear(clr), .oRed(r), .oGreen(g), .oBlue(b),
    .oHs(hs), .oVs(vs), .oCursorX(cx), .oCursorY(cy), .image(img)
  );

  always #5 clk = ~clk;

  // Edges since reset release; at the negedge after edge n, cyc == n.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_img(input string name, input logic [IMG-1:0] exp);
    int first;
    checks++;
    if (img !== exp) begin
      failures++;
      first = -1;
      for (int i = IMG - 1; i >= 0; i--) if (img[i] !== exp[i]) first = i;
      $display("FAIL %s actual_bits_set=%0d required_bits_set=%0d first_diff_bit=%0d",
               name, $countones(img), $countones(exp), first);
    end
  endtask

  function automatic logic [IMG-1:0] bits(input int a, input int c, input int d,
                                          input int e, input int f);
    logic [IMG-1:0] v;
    v = '0;
    if (a >= 0) v[a] = 1'b1;
    if (c >= 0) v[c] = 1'b1;
    if (d >= 0) v[d] = 1'b1;
    if (e >= 0) v[e] = 1'b1;
    if (f >= 0) v[f] = 1'b1;
    return v;
  endfunction

  // Drive one set of inputs for n cycles, then return them to idle.
  task automatic step(input logic m, input logic [8:0] x, input logic [8:0] y,
                      input logic [2:0] bt, input logic cl, input int n);
    mv = m; dx = x; dy = y; btn = bt; clr = cl;
    repeat (n) @(negedge clk);
    mv = 1'b0; dx = '0; dy = '0; btn = '0; clr = 1'b0;
  endtask

  // Check the registered colour of active pixel (p,q). Counter value
  // (q+27)*LINE + 216 + p appears on the outputs after the following edge.
  task automatic pix(input string name, input int p, input int q,
                     input logic [2:0] bt, input logic [11:0] exp);
    int t;
    t = (q + 27) * LINE + 216 + p + 1;
    if (cyc > t - 1) begin
      checks++;
      failures++;
      $display("FAIL %s actual=late_cycle_%0d required=before_%0d", name, cyc, t - 1);
    end else begin
      while (cyc < t - 1) @(negedge clk);
      btn = bt;
      @(negedge clk);
      chk(name, {52'd0, r, g, b}, {52'd0, exp});
    end
  endtask

  typedef struct {
    logic        m;
    logic [8:0]  x;
    logic [8:0]  y;
    int          rep;
    logic [10:0] ex;
    logic [10:0] ey;
  } cur_vec_t;

  cur_vec_t cv[10];
  logic [IMG-1:0] exp0, exp55;
  int hs_low, vs_low, nz;

  initial begin
    cv[0] = '{1'b1, 9'h1FB, 9'h000, 1,  11'd0,   11'd0};
    cv[1] = '{1'b1, 9'h0FF, 9'h000, 10, 11'd799, 11'd0};
    cv[2] = '{1'b1, 9'h101, 9'h000, 1,  11'd544, 11'd0};
    cv[3] = '{1'b1, 9'h000, 9'h1F6, 1,  11'd544, 11'd10};
    cv[4] = '{1'b1, 9'h000, 9'h003, 1,  11'd544, 11'd7};
    cv[5] = '{1'b1, 9'h000, 9'h101, 3,  11'd544, 11'd599};
    cv[6] = '{1'b1, 9'h000, 9'h0FF, 1,  11'd544, 11'd344};
    cv[7] = '{1'b1, 9'h101, 9'h000, 3,  11'd0,   11'd344};
    cv[8] = '{1'b1, 9'h000, 9'h0FF, 2,  11'd0,   11'd0};
    cv[9] = '{1'b0, 9'h064, 9'h000, 2,  11'd0,   11'd0};
    exp0  = bits(0, 1, 32, -1, -1);
    exp55 = bits(165, 164, 166, 133, 197);

    rst_n = 1'b0; mv = 1'b0; dx = '0; dy = '0; btn = '0; clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rgb", {52'd0, r, g, b}, 64'd0);
    chk("rst_hs", {63'd0, hs}, 64'd1);
    chk("rst_vs", {63'd0, vs}, 64'd1);
    chk("rst_cx", {53'd0, cx}, 64'd0);
    chk("rst_cy", {53'd0, cy}, 64'd0);
    chk_img("rst_image", '0);

    // Sync widths and blanking over the first 5000 cycles (all blanking lines).
    rst_n = 1'b1;
    hs_low = 0; vs_low = 0; nz = 0;
    for (int n = 0; n < 5000; n++) begin
      @(negedge clk);
      if (cyc <= 2 * LINE && !hs) hs_low++;
      if (!vs) vs_low++;
      if ({r, g, b} != 12'h000) nz++;
    end
    chk("hs_low_2lines", 64'(hs_low), 64'd256);
    chk("vs_low_cycles", 64'(vs_low), 64'd4224);
    chk("blank_colour", 64'(nz), 64'd0);

    for (int i = 0; i < 10; i++) begin
      step(cv[i].m, cv[i].x, cv[i].y, 3'b000, 1'b0, cv[i].rep);
      chk($sformatf("cursor_x_%0d", i), {53'd0, cx}, {53'd0, cv[i].ex});
      chk($sformatf("cursor_y_%0d", i), {53'd0, cy}, {53'd0, cv[i].ey});
    end

    step(1'b0, 9'h0, 9'h0, 3'b001, 1'b0, 1);
    chk_img("edge_brush", exp0);
    chk("no_wrap_bit31", {63'd0, img[31]}, 64'd0);
    chk("no_wrap_bit992", {63'd0, img[992]}, 64'd0);
    step(1'b0, 9'h0, 9'h0, 3'b001, 1'b0, 2);
    chk_img("paint_idempotent", exp0);
    step(1'b0, 9'h0, 9'h0, 3'b000, 1'b1, 1);
    chk_img("clear", '0);
    step(1'b1, 9'h050, 9'h1B0, 3'b001, 1'b0, 1);
    chk_img("paint_pre_update_cursor", exp0);
    chk("move_80_x", {53'd0, cx}, 64'd80);
    chk("move_80_y", {53'd0, cy}, 64'd80);
    step(1'b0, 9'h0, 9'h0, 3'b000, 1'b1, 1);
    step(1'b0, 9'h0, 9'h0, 3'b001, 1'b0, 1);
    chk_img("paint_cell55", exp55);
    step(1'b0, 9'h0, 9'h0, 3'b011, 1'b0, 1);
    chk_img("paint_over_erase", exp55);
    step(1'b0, 9'h0, 9'h0, 3'b010, 1'b0, 1);
    chk_img("erase_cell55", '0);
    step(1'b0, 9'h0, 9'h0, 3'b001, 1'b0, 1);
    chk_img("repaint_cell55", exp55);
    step(1'b0, 9'h0, 9'h0, 3'b001, 1'b1, 1);
    chk_img("clear_over_paint", '0);
    step(1'b0, 9'h0, 9'h0, 3'b001, 1'b0, 1);
    step(1'b1, 9'h0FF, 9'h01E, 3'b000, 1'b0, 1);
    step(1'b1, 9'h0FF, 9'h000, 3'b000, 1'b0, 1);
    step(1'b1, 9'h06E, 9'h000, 3'b000, 1'b0, 1);
    chk("move_700_x", {53'd0, cx}, 64'd700);
    chk("move_700_y", {53'd0, cy}, 64'd50);
    step(1'b0, 9'h0, 9'h0, 3'b001, 1'b0, 3);
    chk_img("outside_grid_paint", exp55);
    step(1'b0, 9'h0, 9'h0, 3'b010, 1'b0, 2);
    chk_img("outside_grid_erase", exp55);

    // Set up bits 0,1,32 and park the cursor at (100,2) for colour checks.
    step(1'b0, 9'h0, 9'h0, 3'b000, 1'b1, 1);
    step(1'b1, 9'h101, 9'h0FF, 3'b000, 1'b0, 1);
    step(1'b1, 9'h101, 9'h000, 3'b000, 1'b0, 2);
    step(1'b0, 9'h0, 9'h0, 3'b001, 1'b0, 1);
    chk_img("corner_paint_again", exp0);
    step(1'b1, 9'h064, 9'h1FE, 3'b000, 1'b0, 1);
    chk("park_x", {53'd0, cx}, 64'd100);
    chk("park_y", {53'd0, cy}, 64'd2);

    pix("pix_0_0_magenta",   0,   0, 3'b000, 12'hF0F);
    pix("pix_20_0_magenta",  20,  0, 3'b000, 12'hF0F);
    pix("pix_40_0_grey",     40,  0, 3'b000, 12'h888);
    pix("pix_100_0_grey",    100, 0, 3'b000, 12'h888);
    pix("pix_511_0_grey",    511, 0, 3'b000, 12'h888);
    pix("pix_512_0_black",   512, 0, 3'b000, 12'h000);
    pix("pix_600_0_black",   600, 0, 3'b000, 12'h000);
    pix("pix_800_0_blank",   800, 0, 3'b000, 12'h000);
    pix("pix_100_2_red",     100, 2, 3'b000, 12'hF00);
    pix("pix_99_3_grey",     99,  3, 3'b000, 12'h888);
    pix("pix_101_3_green",   101, 3, 3'b100, 12'h0F0);
    pix("pix_107_4_blue",    107, 4, 3'b010, 12'h00F);
    pix("pix_108_4_grey",    108, 4, 3'b010, 12'h888);
    pix("pix_103_5_green",   103, 5, 3'b110, 12'h0F0);
    pix("pix_100_17_red",    100, 17, 3'b000, 12'hF00);
    pix("pix_100_18_grey",   100, 18, 3'b000, 12'h888);

    // Mid-frame asynchronous reset, then first line restarts at hCnt = 0.
    btn = '0;
    rst_n = 1'b0;
    #1;
    chk("midrst_rgb", {52'd0, r, g, b}, 64'd0);
    chk("midrst_cx", {53'd0, cx}, 64'd0);
    chk("midrst_cy", {53'd0, cy}, 64'd0);
    chk_img("midrst_image", '0);
    chk("midrst_vs", {63'd0, vs}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (128) @(negedge clk);
    chk("restart_hs_low_end", {63'd0, hs}, 64'd0);
    @(negedge clk);
    chk("restart_hs_high", {63'd0, hs}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
